// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants, the M-register bundle and its bubble value.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: REG_NONE,
    dst_m: REG_NONE
  };

  function automatic logic stat_exc(input logic [2:0] s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed data memory: 8-byte little-endian comb read, sync write.
// Define DMEM_ALIGN_CHECK_EN to flag any non-8-byte-aligned access as an error.
module data_memory #(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic        commit,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        error
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] base;
  logic          oob;
  logic          mis;

  assign base = addr[AW-1:0];
  assign oob  = addr > 64'(MEM_BYTES - 8);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = |addr[2:0];
`else
  assign mis = 1'b0;
`endif

  assign error = (rd | wr) & (oob | mis);

  always_comb begin
    rdata = '0;
    if (rd && !error) begin
      for (int i = 0; i < 8; i++) begin
        rdata[8*i +: 8] = mem[base + AW'(i)];
      end
    end
  end

  // Contents survive reset; reset only blocks a write in flight.
  always_ff @(posedge clk) begin
    if (wr && commit && !error && !rst) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data access and exception bubble.
// Optional DMEM_ALIGN_CHECK_EN makes misaligned accesses raise ADR.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic [2:0]  W_stat,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valM,
  output logic        m_bubble
);

  m_reg_t      m_q;
  logic        rd;
  logic        wr;
  logic [63:0] addr;
  logic        dmem_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= M_BUBBLE;
    end else if (m_bubble) begin
      m_q <= M_BUBBLE;
    end else begin
      m_q <= '{
        stat:  e_stat,
        icode: e_icode,
        cnd:   e_cnd,
        val_e: e_valE,
        val_a: e_valA,
        dst_e: e_dstE,
        dst_m: e_dstM
      };
    end
  end

  // Stack pops read through valA; everything else addresses with valE.
  always_comb begin
    rd   = 1'b0;
    wr   = 1'b0;
    addr = m_q.val_e;
    unique case (m_q.icode)
      I_MRMOVQ: rd = 1'b1;
      I_RET, I_POPQ: begin
        rd   = 1'b1;
        addr = m_q.val_a;
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: wr = 1'b1;
      default: ;
    endcase
  end

  data_memory #(
    .MEM_BYTES(MEM_BYTES)
  ) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .rd    (rd),
    .wr    (wr),
    .commit(m_q.stat == STAT_AOK),
    .addr  (addr),
    .wdata (m_q.val_a),
    .rdata (m_valM),
    .error (dmem_error)
  );

  assign m_stat   = dmem_error ? STAT_ADR : m_q.stat;
  assign m_bubble = stat_exc(m_stat) | stat_exc(W_stat);

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage against a byte-array reference model.
// Honours DMEM_ALIGN_CHECK_EN the same way the design does.
module tb_memory_stage;

  localparam int MEM = 8192;

  logic        clk;
  logic        rst;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [2:0]  W_stat;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic        m_bubble;

  int checks;
  int failures;

  memory_stage #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd),
    .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .W_stat(W_stat),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_valM(m_valM), .m_bubble(m_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory bytes and the instruction expected in M.
  logic [7:0]  ref_mem [MEM];
  logic [2:0]  x_stat;
  logic [3:0]  x_icode;
  logic        x_cnd;
  logic [63:0] x_valE;
  logic [63:0] x_valA;
  logic [3:0]  x_dstE;
  logic [3:0]  x_dstM;

  task automatic x_nop();
    x_stat = 3'd1; x_icode = 4'd1; x_cnd = 1'b0;
    x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a[12:0]) + i];
    return r;
  endfunction

  function automatic logic x_rd();
    return x_icode == 4'd5 || x_icode == 4'd9 || x_icode == 4'd11;
  endfunction

  function automatic logic x_wr();
    return x_icode == 4'd4 || x_icode == 4'd8 || x_icode == 4'd10;
  endfunction

  function automatic logic [63:0] x_addr();
    return (x_icode == 4'd9 || x_icode == 4'd11) ? x_valA : x_valE;
  endfunction

  function automatic logic x_err();
    logic bad;
    bad = x_addr() > 64'(MEM - 8);
`ifdef DMEM_ALIGN_CHECK_EN
    bad = bad || (x_addr() % 8 != 0);
`endif
    return (x_rd() || x_wr()) && bad;
  endfunction

  function automatic logic [2:0] exp_mstat();
    return x_err() ? 3'd3 : x_stat;
  endfunction

  function automatic logic [63:0] exp_valm();
    return (x_rd() && !x_err()) ? mem_rd(x_addr()) : 64'd0;
  endfunction

  function automatic logic exp_bub();
    return exp_mstat() inside {3'd2, 3'd3, 3'd4} || W_stat inside {3'd2, 3'd3, 3'd4};
  endfunction

  task automatic put(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
    e_stat = 3'd1; e_icode = ic; e_cnd = 1'($urandom);
    e_valE = ve; e_valA = va;
    e_dstE = 4'($urandom); e_dstM = 4'($urandom);
  endtask

  // One clock: commit the model's view of this cycle, then step past the edge.
  task automatic tick();
    if (rst) begin
      x_nop();
    end else begin
      if (x_wr() && !x_err() && x_stat == 3'd1)
        for (int i = 0; i < 8; i++) ref_mem[int'(x_addr() % MEM) + i] = x_valA[8*i +: 8];
      if (exp_bub()) x_nop();
      else begin
        x_stat = e_stat; x_icode = e_icode; x_cnd = e_cnd;
        x_valE = e_valE; x_valA = e_valA; x_dstE = e_dstE; x_dstM = e_dstM;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; W_stat = 3'd1;
    put(4'd6, 64'h40, 64'h7);
    #2;
    checks++; if (M_icode !== 4'd1) begin failures++; $display("FAIL reset_icode got=%0h exp=1", M_icode); end
    checks++; if (M_dstE !== 4'hF) begin failures++; $display("FAIL reset_dste got=%0h exp=f", M_dstE); end
    checks++; if (M_stat !== 3'd1) begin failures++; $display("FAIL reset_stat got=%0h exp=1", M_stat); end
    checks++; if (m_valM !== 64'd0) begin failures++; $display("FAIL reset_valm got=%0h exp=0", m_valM); end
    x_nop();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic prefill();
    for (int a = 0; a < MEM; a += 8) begin
      put(4'd4, 64'(a), {$urandom, $urandom});
      tick();
    end
    put(4'd1, 0, 0);
    tick();
  endtask

  task automatic test_store_load();
    put(4'd4, 64'h100, 64'h1122334455667788); tick();
    put(4'd5, 64'h100, 64'd0); tick();
    checks++; if (m_valM !== 64'h1122334455667788) begin failures++; $display("FAIL st_ld_valm got=%h exp=1122334455667788", m_valM); end
    checks++; if (m_valM[7:0] !== 8'h88) begin failures++; $display("FAIL st_ld_byte got=%h exp=88", m_valM[7:0]); end
    checks++; if (m_stat !== 3'd1) begin failures++; $display("FAIL st_ld_stat got=%0d exp=1", m_stat); end
  endtask

  task automatic test_push_pop();
    put(4'd10, 64'h1FF8, 64'd5); tick();
    put(4'd11, 64'h0, 64'h1FF8); tick();
    checks++; if (m_valM !== 64'd5) begin failures++; $display("FAIL pop_valm got=%h exp=5", m_valM); end
    checks++; if (m_stat !== 3'd1) begin failures++; $display("FAIL pop_stat got=%0d exp=1", m_stat); end
  endtask

  task automatic test_bounds();
    logic [63:0] old;
    old = mem_rd(64'h200);
    put(4'd5, 64'h1FF9, 64'd0); tick();
    checks++; if (m_stat !== 3'd3) begin failures++; $display("FAIL oob_stat got=%0d exp=3", m_stat); end
    checks++; if (m_valM !== 64'd0) begin failures++; $display("FAIL oob_valm got=%h exp=0", m_valM); end
    checks++; if (m_bubble !== 1'b1) begin failures++; $display("FAIL oob_bubble got=%b exp=1", m_bubble); end
    put(4'd4, 64'h200, 64'hDEAD_BEEF_0BAD_F00D); tick();
    checks++; if (M_icode !== 4'd1) begin failures++; $display("FAIL oob_next_icode got=%0h exp=1", M_icode); end
    checks++; if (M_dstM !== 4'hF) begin failures++; $display("FAIL oob_next_dstm got=%0h exp=f", M_dstM); end
    put(4'd5, 64'h200, 64'd0); tick();
    checks++; if (m_valM !== old) begin failures++; $display("FAIL oob_discard got=%h exp=%h", m_valM, old); end
    put(4'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0); tick();
    checks++; if (m_stat !== 3'd3) begin failures++; $display("FAIL wrap_stat got=%0d exp=3", m_stat); end
    put(4'd1, 0, 0); tick();
  endtask

  task automatic test_w_stat();
    logic [63:0] old;
    old = mem_rd(64'h308);
    put(4'd4, 64'h300, 64'hA5A5_0101_5A5A_1010); tick();
    W_stat = 3'd2;
    put(4'd4, 64'h308, 64'h0123_4567_89AB_CDEF);
    #1;
    checks++; if (M_stat !== 3'd1) begin failures++; $display("FAIL wstat_mstat got=%0d exp=1", M_stat); end
    checks++; if (m_bubble !== 1'b1) begin failures++; $display("FAIL wstat_bubble got=%b exp=1", m_bubble); end
    tick();
    checks++; if (M_icode !== 4'd1) begin failures++; $display("FAIL wstat_next_icode got=%0h exp=1", M_icode); end
    W_stat = 3'd1;
    put(4'd5, 64'h300, 64'd0); tick();
    checks++; if (m_valM !== 64'hA5A5_0101_5A5A_1010) begin failures++; $display("FAIL wstat_store got=%h exp=a5a501015a5a1010", m_valM); end
    put(4'd5, 64'h308, 64'd0); tick();
    checks++; if (m_valM !== old) begin failures++; $display("FAIL wstat_discard got=%h exp=%h", m_valM, old); end
  endtask

  task automatic test_reset_write();
    logic [63:0] old;
    old = mem_rd(64'h400);
    put(4'd6, 64'h40, 64'd1); tick();
    checks++; if (M_icode !== 4'd6) begin failures++; $display("FAIL rst_pre_icode got=%0h exp=6", M_icode); end
    put(4'd4, 64'h400, 64'hFACE_FACE_FACE_FACE); tick();
    rst = 1'b1;
    #1;
    checks++; if (M_icode !== 4'd1) begin failures++; $display("FAIL rst_async_icode got=%0h exp=1", M_icode); end
    tick();
    rst = 1'b0;
    put(4'd5, 64'h400, 64'd0); tick();
    checks++; if (m_valM !== old) begin failures++; $display("FAIL rst_cancel got=%h exp=%h", m_valM, old); end
  endtask

  task automatic test_align();
    logic [63:0] old;
    logic [63:0] d;
    old = mem_rd(64'h500);
    d = 64'h8877_6655_4433_2211;
    put(4'd4, 64'h508, 64'h1); tick();
    checks++; if (m_stat !== 3'd1) begin failures++; $display("FAIL align_ok_stat got=%0d exp=1", m_stat); end
    put(4'd4, 64'h503, d); tick();
`ifdef DMEM_ALIGN_CHECK_EN
    checks++; if (m_stat !== 3'd3) begin failures++; $display("FAIL align_bad_stat got=%0d exp=3", m_stat); end
    put(4'd1, 0, 0); tick();
    put(4'd5, 64'h500, 64'd0); tick();
    checks++; if (m_valM !== old) begin failures++; $display("FAIL align_unchanged got=%h exp=%h", m_valM, old); end
    put(4'd5, 64'h504, 64'd0); tick();
    checks++; if (m_stat !== 3'd3) begin failures++; $display("FAIL align_104_stat got=%0d exp=3", m_stat); end
    put(4'd1, 0, 0); tick();
`else
    checks++; if (m_stat !== 3'd1) begin failures++; $display("FAIL unalign_stat got=%0d exp=1", m_stat); end
    put(4'd5, 64'h500, 64'd0); tick();
    checks++; if (m_valM !== {d[39:0], old[23:0]}) begin failures++; $display("FAIL unalign_merge got=%h exp=%h", m_valM, {d[39:0], old[23:0]}); end
    put(4'd4, 64'h600, d); tick();
    put(4'd5, 64'h604, 64'd0); tick();
    checks++; if (m_valM[31:0] !== d[63:32]) begin failures++; $display("FAIL overlap_low got=%h exp=%h", m_valM[31:0], d[63:32]); end
`endif
  endtask

  task automatic test_random();
    logic [63:0] ve;
    logic [63:0] va;
    for (int n = 0; n < 400; n++) begin
      ve = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM - 1));
      va = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM - 1));
      put(4'($urandom_range(0, 11)), ve, {$urandom_range(0, 1) == 0 ? 32'd0 : $urandom, va[31:0]});
      if (e_icode inside {4'd9, 4'd11}) e_valA = va;
      e_stat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      tick();
      checks++; if (M_icode !== x_icode) begin failures++; $display("FAIL rnd_icode n=%0d got=%0h exp=%0h", n, M_icode, x_icode); end
      checks++; if (M_stat !== x_stat) begin failures++; $display("FAIL rnd_mstat n=%0d got=%0d exp=%0d", n, M_stat, x_stat); end
      checks++; if ({M_cnd, M_dstE, M_dstM} !== {x_cnd, x_dstE, x_dstM}) begin failures++; $display("FAIL rnd_ctl n=%0d got=%h exp=%h", n, {M_cnd, M_dstE, M_dstM}, {x_cnd, x_dstE, x_dstM}); end
      checks++; if ({M_valE, M_valA} !== {x_valE, x_valA}) begin failures++; $display("FAIL rnd_vals n=%0d got=%h exp=%h", n, {M_valE, M_valA}, {x_valE, x_valA}); end
      checks++; if (m_stat !== exp_mstat()) begin failures++; $display("FAIL rnd_m_stat n=%0d got=%0d exp=%0d", n, m_stat, exp_mstat()); end
      checks++; if (m_valM !== exp_valm()) begin failures++; $display("FAIL rnd_valm n=%0d got=%h exp=%h", n, m_valM, exp_valm()); end
      checks++; if (m_bubble !== exp_bub()) begin failures++; $display("FAIL rnd_bubble n=%0d got=%b exp=%b", n, m_bubble, exp_bub()); end
    end
    W_stat = 3'd1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    prefill();
    test_store_load();
    test_push_pop();
    test_bounds();
    test_w_stat();
    test_reset_write();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
